vx_issue_perf_ctrs: RTL

//  Producer side of the pipeline perf-counter bundle: counts issue-stage stall events and active threads
//  and drives the issue outputs (ibf/scb/lsu/csr/alu/fpu/gpu stalls, active_threads) read by the perf/CSR slave.

---
 rtl/vx_perf_pkg.sv | 38 +++
 rtl/vx_issue_perf_ctrs_if.sv | 41 ++++
 rtl/vx_perf_accum.sv | 28 ++
 rtl/vx_issue_perf_ctrs.sv | 86 ++++++++
 4 files changed

// File: rtl/vx_perf_pkg.sv
// rtl/vx_perf_pkg.sv - unit codes, counter indices and popcount helper for the issue perf counters
package vx_perf_pkg;

    localparam int EX_BITS   = 3;
    localparam int NUM_UNITS = 5;

    typedef enum logic [EX_BITS-1:0] {
        EX_LSU = 3'd0,
        EX_CSR = 3'd1,
        EX_ALU = 3'd2,
        EX_FPU = 3'd3,
        EX_GPU = 3'd4
    } ex_unit_e;

    localparam int NUM_STALL_CTRS = 7;
    localparam int CTR_IBF = 0;
    localparam int CTR_SCB = 1;
    localparam int CTR_LSU = 2;
    localparam int CTR_CSR = 3;
    localparam int CTR_ALU = 4;
    localparam int CTR_FPU = 5;
    localparam int CTR_GPU = 6;

    // Dispatch unit stall counters sit contiguously after ibf/scb, in unit-code order
    function automatic int unit_ctr_idx(input int unit);
        return CTR_LSU + unit;
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vx_issue_perf_ctrs_if.sv
// rtl/vx_issue_perf_ctrs_if.sv - issue-stage event inputs and perf counter outputs
interface vx_issue_perf_ctrs_if #(
    parameter int NUM_THREADS = 4,
    parameter int CTR_BITS    = 44
);
    import vx_perf_pkg::*;

    logic                   perf_en;
    logic                   clear;
    logic                   ibf_stall;
    logic                   scb_stall;
    logic                   disp_valid;
    logic [EX_BITS-1:0]     disp_unit;
    logic                   disp_ready;
    logic                   issue_fire;
    logic [NUM_THREADS-1:0] issue_tmask;

    logic [CTR_BITS-1:0]    ibf_stalls;
    logic [CTR_BITS-1:0]    scb_stalls;
    logic [CTR_BITS-1:0]    lsu_stalls;
    logic [CTR_BITS-1:0]    csr_stalls;
    logic [CTR_BITS-1:0]    alu_stalls;
    logic [CTR_BITS-1:0]    fpu_stalls;
    logic [CTR_BITS-1:0]    gpu_stalls;
    logic [CTR_BITS-1:0]    active_threads;

    modport master (
        output perf_en, clear, ibf_stall, scb_stall, disp_valid, disp_unit, disp_ready,
               issue_fire, issue_tmask,
        input  ibf_stalls, scb_stalls, lsu_stalls, csr_stalls, alu_stalls, fpu_stalls,
               gpu_stalls, active_threads
    );

    modport slave (
        input  perf_en, clear, ibf_stall, scb_stall, disp_valid, disp_unit, disp_ready,
               issue_fire, issue_tmask,
        output ibf_stalls, scb_stalls, lsu_stalls, csr_stalls, alu_stalls, fpu_stalls,
               gpu_stalls, active_threads
    );

endinterface

// File: rtl/vx_perf_accum.sv
// rtl/vx_perf_accum.sv - single wrap-around event accumulator
module vx_perf_accum #(
    parameter int CTR_BITS = 44,
    parameter int INC_BITS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic [INC_BITS-1:0] i_inc,
    output logic [CTR_BITS-1:0] o_count
);

    logic [CTR_BITS-1:0] r_count;

    // Modulo 2^CTR_BITS: the adder simply drops its carry, so all-ones rolls to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CTR_BITS'(i_inc);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vx_issue_perf_ctrs.sv
// rtl/vx_issue_perf_ctrs.sv - issue-stage stall and active-thread perf counters
// Stage 1 registers this cycle's events; stage 2 folds them into the accumulators.
module vx_issue_perf_ctrs
    import vx_perf_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int CTR_BITS    = 44,
    parameter int FPU_ENABLE  = 1
) (
    input  logic               clk,
    input  logic               reset,
    vx_issue_perf_ctrs_if.slave bus
);

    localparam int THR_BITS = $clog2(NUM_THREADS) + 1;

    logic [NUM_STALL_CTRS-1:0] w_evt;
    logic [NUM_STALL_CTRS-1:0] r_evt;
    logic [THR_BITS-1:0]       w_thr;
    logic [THR_BITS-1:0]       r_thr;
    logic [CTR_BITS-1:0]       w_ctr [NUM_STALL_CTRS];
    logic [CTR_BITS-1:0]       w_thr_ctr;

    always_comb begin
        w_evt          = '0;
        w_evt[CTR_IBF] = bus.ibf_stall;
        w_evt[CTR_SCB] = bus.scb_stall;
        // Codes 5-7 match no unit and therefore never raise a stall bit
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_evt[unit_ctr_idx(u)] = bus.disp_valid & ~bus.disp_ready
                                   & (bus.disp_unit == EX_BITS'(u));
        end
        if (FPU_ENABLE == 0) begin
            w_evt[CTR_FPU] = 1'b0;
        end
        w_thr = bus.issue_fire ? THR_BITS'(popcount32(32'(bus.issue_tmask))) : '0;
    end

    // Disabled or clearing cycles register nothing, so those samples can never count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt <= '0;
            r_thr <= '0;
        end else if (bus.clear || !bus.perf_en) begin
            r_evt <= '0;
            r_thr <= '0;
        end else begin
            r_evt <= w_evt;
            r_thr <= w_thr;
        end
    end

    for (genvar g = 0; g < NUM_STALL_CTRS; g++) begin : g_stall_ctr
        vx_perf_accum #(
            .CTR_BITS (CTR_BITS),
            .INC_BITS (1)
        ) u_accum (
            .clk     (clk),
            .reset   (reset),
            .i_clear (bus.clear),
            .i_inc   (r_evt[g]),
            .o_count (w_ctr[g])
        );
    end

    vx_perf_accum #(
        .CTR_BITS (CTR_BITS),
        .INC_BITS (THR_BITS)
    ) u_thr_accum (
        .clk     (clk),
        .reset   (reset),
        .i_clear (bus.clear),
        .i_inc   (r_thr),
        .o_count (w_thr_ctr)
    );

    assign bus.ibf_stalls     = w_ctr[CTR_IBF];
    assign bus.scb_stalls     = w_ctr[CTR_SCB];
    assign bus.lsu_stalls     = w_ctr[CTR_LSU];
    assign bus.csr_stalls     = w_ctr[CTR_CSR];
    assign bus.alu_stalls     = w_ctr[CTR_ALU];
    assign bus.fpu_stalls     = (FPU_ENABLE != 0) ? w_ctr[CTR_FPU] : '0;
    assign bus.gpu_stalls     = w_ctr[CTR_GPU];
    assign bus.active_threads = w_thr_ctr;

endmodule
